// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its PLL and system-reset consumers.
interface pll_lock_sequencer_if #(
  parameter int unsigned RTY_W = 4
);
  logic             enable;
  logic             pll_lock;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             locked;
  logic             fail;
  logic [RTY_W-1:0] retry_cnt;
  logic [2:0]       state;

  modport master (
    input  enable, pll_lock,
    output pll_rst, sys_rst_n, locked, fail, retry_cnt, state
  );

  modport slave (
    output enable, pll_lock,
    input  pll_rst, sys_rst_n, locked, fail, retry_cnt, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Brings a PLL from reset to a filtered lock with timeout/retry, then gates the downstream reset.
// Runs on the PLL reference clock; all outputs are flops loaded from the next state.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_FILTER  = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RTY_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_lock_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FILTER    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAILED    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [1:0]       lock_sync_q;
  logic             lock_s;
  logic             timeout;
  logic             pll_rst_q, sys_rst_n_q, locked_q, fail_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync_q <= 2'b00;
    else        lock_sync_q <= {lock_sync_q[0], bus.pll_lock};
  end

  assign lock_s = lock_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      fcnt_q      <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      fcnt_q      <= fcnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAILED);
      sys_rst_n_q <= (state_d == ST_RUN);
      locked_q    <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAILED);
    end
  end

  // Next state and counters; ENABLE low wins over everything else
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    fcnt_d  = fcnt_q;
    retry_d = retry_q;
    timeout = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
      tcnt_d  = '0;
      fcnt_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          rcnt_d  = '0;
          retry_d = '0;
        end
        ST_RESET: begin
          rcnt_d = sat_inc(rcnt_q);
          if (rcnt_q >= RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            tcnt_d  = '0;
          end
        end
        ST_WAIT_LOCK: begin
          tcnt_d = sat_inc(tcnt_q);
          if (lock_s) begin
            state_d = ST_FILTER;
            fcnt_d  = '0;
          end else if (tcnt_q >= TO_LAST) begin
            timeout = 1'b1;
          end
        end
        ST_FILTER: begin
          // Timeout budget spans both lock-wait and filtering, so tcnt survives aborts
          tcnt_d = sat_inc(tcnt_q);
          if (tcnt_q >= TO_LAST) begin
            timeout = 1'b1;
          end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            fcnt_d  = '0;
          end else if (fcnt_q >= FLT_LAST) begin
            state_d = ST_RUN;
          end else begin
            fcnt_d = sat_inc(fcnt_q);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            rcnt_d  = '0;
            retry_d = '0;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
          tcnt_d  = '0;
          fcnt_d  = '0;
          retry_d = '0;
        end
      endcase

      if (timeout) begin
        if (retry_q >= RTY_MAX) begin
          state_d = ST_FAILED;
        end else begin
          state_d = ST_RESET;
          rcnt_d  = '0;
          retry_d = retry_q + RTY_W'(1);
        end
      end
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues expected output changes with their
// cycle stamps, a negedge monitor pops one entry per observed change of the output tuple.
module tb_pll_lock_sequencer;

  localparam int unsigned RTY_W = 4;
  localparam int unsigned TW    = 3 + 4 + RTY_W;

  typedef logic [TW-1:0] tup_t;
  typedef struct packed { int cyc; tup_t tup; } exp_t;
  typedef struct { string name; tup_t act; tup_t want; } dir_t;

  // {state, pll_rst, sys_rst_n, locked, fail, retry_cnt}
  localparam tup_t T_IDLE = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

  logic clk;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  bit   done   = 1'b0;
  bit   drained_chk = 1'b0;
  tup_t prev;
  tup_t cur;
  exp_t em;
  dir_t dm;
  exp_t exp_q[$];
  dir_t dir_q[$];

  pll_lock_sequencer_if #(.RTY_W(RTY_W)) bus ();

  pll_lock_sequencer #(
    .RST_CYCLES  (4),
    .LOCK_FILTER (8),
    .LOCK_TIMEOUT(32),
    .MAX_RETRY   (2),
    .CNT_W       (16),
    .RTY_W       (RTY_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic tup_t tp(input logic [2:0] s, input logic pr, input logic sr,
                              input logic lk, input logic fl, input logic [RTY_W-1:0] rt);
    return {s, pr, sr, lk, fl, rt};
  endfunction

  function automatic tup_t t_rst (input int r); return tp(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, RTY_W'(r)); endfunction
  function automatic tup_t t_wait(input int r); return tp(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, RTY_W'(r)); endfunction
  function automatic tup_t t_filt(input int r); return tp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, RTY_W'(r)); endfunction
  function automatic tup_t t_run (input int r); return tp(3'd4, 1'b0, 1'b1, 1'b1, 1'b0, RTY_W'(r)); endfunction
  function automatic tup_t t_fail(input int r); return tp(3'd5, 1'b1, 1'b0, 1'b0, 1'b1, RTY_W'(r)); endfunction

  function automatic tup_t dut_tup();
    return {bus.state, bus.pll_rst, bus.sys_rst_n, bus.locked, bus.fail, bus.retry_cnt};
  endfunction

  task automatic expect_at(input int c, input tup_t t);
    exp_t e;
    e.cyc = c;
    e.tup = t;
    exp_q.push_back(e);
  endtask

  task automatic dir_chk(input string n, input tup_t a, input tup_t w);
    dir_t d;
    d.name = n;
    d.act  = a;
    d.want = w;
    dir_q.push_back(d);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic go_idle();
    int c;
    c = cyc;
    bus.enable   = 1'b0;
    bus.pll_lock = 1'b0;
    expect_at(c + 1, T_IDLE);
    wait_until(c + 2);
  endtask

  task automatic start_seq(output int w);
    int c;
    c = cyc;
    expect_at(c + 1, t_rst(0));
    expect_at(c + 5, t_wait(0));
    bus.enable = 1'b1;
    w = c + 5;
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation
  always @(negedge clk) begin
    while (dir_q.size() > 0) begin
      dm = dir_q.pop_front();
      checks++;
      if (dm.act !== dm.want) begin
        errors++;
        $display("FAIL %s got=%h want=%h", dm.name, dm.act, dm.want);
      end
    end
    if (!mon_on) begin
      prev = T_IDLE;
    end else begin
      cur = dut_tup();
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h want=%h", cyc, cur, prev);
        end else begin
          em = exp_q.pop_front();
          if (cur !== em.tup || cyc != em.cyc) begin
            errors++;
            $display("FAIL transition got tup=%h cyc=%0d want tup=%h cyc=%0d",
                     cur, cyc, em.tup, em.cyc);
          end
        end
        prev = cur;
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        em = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_transition cyc=%0d got=%h want tup=%h cyc=%0d",
                 cyc, cur, em.tup, em.cyc);
      end
    end
    if (done && !drained_chk) begin
      drained_chk = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL queue_drained pending=%0d want=0", exp_q.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w2, w3, l, p, c;
    rst_n        = 1'b0;
    bus.enable   = 1'b0;
    bus.pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    dir_chk("reset_state", dut_tup(), T_IDLE);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    wait_until(cyc + 2);

    // Nominal: lock 10 cycles after PLL_RST falls, RUN 3+8 edges after the lock edge
    start_seq(w);
    wait_until(w + 10);
    l = cyc;
    bus.pll_lock = 1'b1;
    expect_at(l + 3,  t_filt(0));
    expect_at(l + 11, t_run(0));
    wait_until(l + 14);
    go_idle();

    // Chatter: 5 high, 2 low, then steady high
    start_seq(w);
    wait_until(w + 5);
    l = cyc;
    bus.pll_lock = 1'b1;
    expect_at(l + 3,  t_filt(0));
    expect_at(l + 8,  t_wait(0));
    expect_at(l + 10, t_filt(0));
    expect_at(l + 18, t_run(0));
    wait_until(l + 5);
    bus.pll_lock = 1'b0;
    wait_until(l + 7);
    bus.pll_lock = 1'b1;
    wait_until(l + 20);
    go_idle();

    // Timeout and retry exhaustion with lock held low
    start_seq(w);
    expect_at(w + 32,  t_rst(1));
    expect_at(w + 36,  t_wait(1));
    expect_at(w + 68,  t_rst(2));
    expect_at(w + 72,  t_wait(2));
    expect_at(w + 104, t_fail(2));
    wait_until(w + 108);
    go_idle();

    // Late chatter: tcnt kept across the abort, so timeout lands exactly on the would-be RUN edge
    start_seq(w);
    wait_until(w + 14);
    bus.pll_lock = 1'b1;
    expect_at(w + 17, t_filt(0));
    expect_at(w + 22, t_wait(0));
    expect_at(w + 24, t_filt(0));
    expect_at(w + 32, t_rst(1));
    expect_at(w + 36, t_wait(1));
    expect_at(w + 37, t_filt(1));
    expect_at(w + 45, t_run(1));
    wait_until(w + 19);
    bus.pll_lock = 1'b0;
    wait_until(w + 21);
    bus.pll_lock = 1'b1;
    wait_until(w + 48);

    // Lock loss in RUN with one retry consumed: one-cycle dropout
    p = cyc;
    bus.pll_lock = 1'b0;
    expect_at(p + 3,  t_rst(0));
    expect_at(p + 7,  t_wait(0));
    expect_at(p + 8,  t_filt(0));
    expect_at(p + 16, t_run(0));
    wait_until(p + 1);
    bus.pll_lock = 1'b1;
    wait_until(p + 18);
    go_idle();

    // ENABLE drop in WAIT_LOCK after a retry, then restart with a fresh budget
    start_seq(w);
    expect_at(w + 32, t_rst(1));
    expect_at(w + 36, t_wait(1));
    wait_until(w + 38);
    go_idle();
    start_seq(w2);

    // Async reset mid-FILTER, then a clean restart to RUN
    wait_until(w2 + 2);
    bus.pll_lock = 1'b1;
    expect_at(w2 + 5, t_filt(0));
    wait_until(w2 + 7);
    #2;
    rst_n = 1'b0;
    #1;
    dir_chk("async_reset_now", dut_tup(), T_IDLE);
    expect_at(w2 + 8, T_IDLE);
    bus.pll_lock = 1'b0;
    wait_until(w2 + 10);
    dir_chk("async_reset_hold", dut_tup(), T_IDLE);
    rst_n = 1'b1;
    c = cyc;
    expect_at(c + 1, t_rst(0));
    expect_at(c + 5, t_wait(0));
    w3 = c + 5;
    wait_until(w3 + 2);
    bus.pll_lock = 1'b1;
    expect_at(w3 + 5,  t_filt(0));
    expect_at(w3 + 13, t_run(0));
    wait_until(w3 + 16);

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
